// File: rtl/sccb_pkg.sv
// Shared SCCB responder definitions: FSM state encoding and bus-level constants.
`timescale 1ns / 100ps
package sccb_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StId,
    StIdAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdNa,
    StIgnore
  } sccb_state_e;

  // Last bit of the ID byte selects transfer direction
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  // Level on SIO_D that acknowledges a byte
  localparam logic ACK      = 1'b0;

endpackage

// File: rtl/sccb_bus_sync.sv
// Synchronises SIO_C/SIO_D into iclk and derives START/STOP and SCL edge events.
`timescale 1ns / 100ps
module sccb_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic iscl,
  input  logic isda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_h_q;
  logic                   sda_h_q;
  logic                   scl_s;

  // Reset to the idle-bus level so releasing reset never fakes a START or STOP
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], iscl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], isda};
      scl_h_q    <= scl_sync_q[SYNC_STAGES-1];
      sda_h_q    <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    scl_s     = scl_sync_q[SYNC_STAGES-1];
    sda_s     = sda_sync_q[SYNC_STAGES-1];
    scl_rise  = scl_s & ~scl_h_q;
    scl_fall  = ~scl_s & scl_h_q;
    start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
    stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave with an internal register file; decodes 3-phase writes and 2+2-phase reads.
`timescale 1ns / 100ps
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h30,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              iscl,
  input  logic              isda,
  output logic              osda_oe,
  output logic              owr_stb,
  output logic [ADDR_W-1:0] owr_addr,
  output logic [7:0]        owr_data,
  output logic              obusy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  sccb_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .iscl     (iscl),
    .isda     (isda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  sccb_state_e       state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        regfile_q [DEPTH];
  logic              sda_oe_q;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic [7:0]        byte_in;

  assign byte_in = {shift_q[6:0], sda_s};

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile_q[i] <= '0;
    end else begin
      wr_stb_q <= 1'b0;
      if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= StId;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else if (scl_rise) begin
        case (state_q)
          StId, StSub, StWdata: begin
            if (bit_cnt_q < 4'd8) begin
              shift_q   <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7 && state_q == StSub) ptr_q <= ADDR_W'(byte_in);
              if (bit_cnt_q == 4'd7 && state_q == StWdata) begin
                regfile_q[ptr_q] <= byte_in;
                wr_stb_q         <= 1'b1;
                wr_addr_q        <= ptr_q;
                wr_data_q        <= byte_in;
              end
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          StId: begin
            if (bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_q  <= StIdAck;
                sda_oe_q <= ~ACK;
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StSub: begin
            if (bit_cnt_q == 4'd8) begin
              state_q  <= StSubAck;
              sda_oe_q <= ~ACK;
            end
          end
          StWdata: begin
            if (bit_cnt_q == 4'd8) begin
              state_q  <= StWdataAck;
              sda_oe_q <= ~ACK;
            end
          end
          StIdAck: begin
            bit_cnt_q <= '0;
            case (shift_q[0])
              RW_WRITE: begin
                state_q  <= StSub;
                sda_oe_q <= 1'b0;
              end
              RW_READ: begin
                // Read byte is latched here and its MSB presented on this same fall
                state_q  <= StRdata;
                shift_q  <= regfile_q[ptr_q];
                sda_oe_q <= ~regfile_q[ptr_q][7];
              end
            endcase
          end
          StSubAck: begin
            state_q   <= StWdata;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
          end
          StWdataAck: begin
            state_q  <= StIgnore;
            sda_oe_q <= 1'b0;
          end
          StRdata: begin
            if (bit_cnt_q == 4'd7) begin
              state_q  <= StRdNa;
              sda_oe_q <= 1'b0;
            end else begin
              shift_q   <= {shift_q[6:0], 1'b0};
              sda_oe_q  <= ~shift_q[6];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          StRdNa: state_q <= StIgnore;
          default: ;
        endcase
      end
    end
  end

  assign osda_oe  = sda_oe_q;
  assign owr_stb  = wr_stb_q;
  assign owr_addr = wr_addr_q;
  assign owr_data = wr_data_q;
  assign obusy    = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-banged SCCB master with pull-up and a byte-level register model.
`timescale 1ns / 100ps
module tb_sccb_responder;

  localparam int Q = 625;  // quarter SCL period
  localparam logic [6:0] DEV = 7'h30;

  logic       iclk = 1'b0;
  logic       irst_n = 1'b0;
  logic       iscl = 1'b1;
  logic       m_low = 1'b0;
  logic       sda_line;
  logic       osda_oe;
  logic       owr_stb;
  logic [7:0] owr_addr;
  logic [7:0] owr_data;
  logic       obusy;

  // Open-drain bus with pull-up: low if either side pulls
  assign sda_line = ~(m_low | osda_oe);

  sccb_responder #(
    .DEV_ADDR   (DEV),
    .ADDR_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .iclk    (iclk),
    .irst_n  (irst_n),
    .iscl    (iscl),
    .isda    (sda_line),
    .osda_oe (osda_oe),
    .owr_stb (owr_stb),
    .owr_addr(owr_addr),
    .owr_data(owr_data),
    .obusy   (obusy)
  );

  always #18.5 iclk = ~iclk;

  int n_checks = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] last_addr = '0;
  logic [7:0] last_data = '0;

  logic [7:0] m_reg [256];
  logic [7:0] m_ptr;

  always @(negedge iclk) begin
    if (owr_stb) begin
      stb_cnt++;
      last_addr = owr_addr;
      last_data = owr_data;
    end
    if (osda_oe) oe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_start();
    m_low = 1'b0; iscl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    iscl = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; #Q;
    iscl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    iscl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    iscl = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic v);
    m_low = ~v; #Q;
    iscl = 1'b1; #(2 * Q);
    iscl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic v);
    m_low = 1'b0; #Q;
    iscl = 1'b1; #Q;
    v = sda_line; #Q;
    iscl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_low = 1'b0; #Q;
    iscl = 1'b1; #Q;
    ack = ~sda_line; #Q;
    iscl = 1'b0; #Q;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
    write_bit(1'b1);  // NACK
  endtask

  // Write-direction (or foreign-ID) transfer of n bytes, checked against the model
  task automatic wr_xfer(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    logic ack;
    int stb0, oe0;
    bit valid;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    stb0 = stb_cnt;
    oe0 = oe_cnt;
    valid = (b0[7:1] == DEV) && (b0[0] == 1'b0);
    bus_start();
    check_eq("busy_after_start", obusy, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(b[i], ack);
      check_eq($sformatf("ack_byte%0d", i), ack, valid && (i < 3));
      if (valid && i == 1) m_ptr = b[i];
      if (valid && i == 2) m_reg[m_ptr] = b[i];
    end
    bus_stop();
    check_eq("stb_count", stb_cnt - stb0, (valid && n >= 3) ? 1 : 0);
    if (valid && n >= 3) begin
      check_eq("stb_addr", last_addr, b1);
      check_eq("stb_data", last_data, b2);
    end
    if (!valid) check_eq("foreign_id_no_drive", oe_cnt - oe0, 0);
    check_eq("busy_after_stop", obusy, 0);
    check_eq("oe_after_stop", osda_oe, 0);
  endtask

  task automatic rd_xfer();
    logic ack;
    logic [7:0] d;
    int stb0;
    stb0 = stb_cnt;
    bus_start();
    write_byte({DEV, 1'b1}, ack);
    check_eq("ack_read_id", ack, 1);
    read_byte(d);
    bus_stop();
    check_eq("read_data", d, m_reg[m_ptr]);
    check_eq("read_no_stb", stb_cnt - stb0, 0);
    check_eq("busy_after_read", obusy, 0);
  endtask

  task automatic read_at(input logic [7:0] a);
    wr_xfer(2, {DEV, 1'b0}, a, 8'h00, 8'h00);
    rd_xfer();
  endtask

  initial begin
    logic ack;
    logic v;
    logic [7:0] wrong_ids [4];
    wrong_ids[0] = 8'h42; wrong_ids[1] = 8'h20; wrong_ids[2] = 8'hA0; wrong_ids[3] = 8'h62;
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
    m_ptr = 8'h00;

    #100;
    check_eq("rst_oe", osda_oe, 0);
    check_eq("rst_stb", owr_stb, 0);
    check_eq("rst_addr", owr_addr, 0);
    check_eq("rst_data", owr_data, 0);
    check_eq("rst_busy", obusy, 0);
    #7 irst_n = 1'b1;
    #(4 * Q);

    // Basic 3-phase write
    wr_xfer(3, 8'h60, 8'h12, 8'h80, 8'h00);
    read_at(8'h12);

    // 2-phase write then read
    wr_xfer(3, 8'h60, 8'h0A, 8'h26, 8'h00);
    wr_xfer(2, 8'h60, 8'h0A, 8'h00, 8'h00);
    rd_xfer();

    // Foreign ID then a valid transfer
    wr_xfer(3, 8'h42, 8'h12, 8'h55, 8'h00);
    read_at(8'h12);

    // Repeated START part-way through the sub-address
    begin
      int stb0;
      stb0 = stb_cnt;
      bus_start();
      write_byte(8'h60, ack);
      check_eq("rs_ack_id0", ack, 1);
      write_bit(1'b0); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
      bus_rstart();
      write_byte(8'h60, ack); check_eq("rs_ack_id1", ack, 1);
      write_byte(8'h05, ack); check_eq("rs_ack_sub", ack, 1);
      write_byte(8'hAA, ack); check_eq("rs_ack_data", ack, 1);
      bus_stop();
      m_ptr = 8'h05;
      m_reg[8'h05] = 8'hAA;
      check_eq("rs_stb_count", stb_cnt - stb0, 1);
      check_eq("rs_stb_addr", last_addr, 8'h05);
      check_eq("rs_stb_data", last_data, 8'hAA);
    end
    read_at(8'h12);
    read_at(8'h05);

    // Extra data byte is neither ACKed nor written
    wr_xfer(4, 8'h60, 8'h20, 8'h11, 8'h22);
    read_at(8'h20);
    read_at(8'h21);

    // Randomised traffic
    for (int it = 0; it < 12; it++) begin
      int kind;
      logic [7:0] id;
      kind = $urandom_range(0, 2);
      id = ($urandom_range(0, 3) == 0) ? wrong_ids[$urandom_range(0, 3)] : 8'h60;
      case (kind)
        0: wr_xfer($urandom_range(3, 4), id, 8'($urandom_range(0, 7)), 8'($urandom),
                   8'($urandom));
        1: wr_xfer(2, id, 8'($urandom_range(0, 7)), 8'h00, 8'h00);
        default: rd_xfer();
      endcase
    end

    // Reset during a read of an all-zero register (responder pulls every bit low)
    wr_xfer(2, 8'h60, 8'h77, 8'h00, 8'h00);
    bus_start();
    write_byte(8'h61, ack);
    check_eq("rst_rd_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      read_bit(v);
      check_eq("rst_rd_bit", v, 0);
    end
    m_low = 1'b0; #Q;
    iscl = 1'b1; #(Q / 2);
    check_eq("oe_before_rst", osda_oe, 1);
    irst_n = 1'b0;
    #1;
    check_eq("oe_async_rst", osda_oe, 0);
    check_eq("busy_async_rst", obusy, 0);
    #(Q + 7);
    irst_n = 1'b1;
    #(2 * Q);
    for (int i = 0; i < 256; i++) m_reg[i] = 8'h00;
    m_ptr = 8'h00;
    rd_xfer();
    read_at(8'h12);
    read_at(8'h0A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
